// File: rtl/peridot_qspi_arbiter_pkg.sv
// Shared types for the QSPI PSRAM arbiter: grant states and read-tag width.
package peridot_qspi_arbiter_pkg;

  localparam int TAG_W = 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e grant_state(input logic port);
    return port ? ARB_GNT1 : ARB_GNT0;
  endfunction

endpackage

// File: rtl/peridot_qspi_arb_tagfifo.sv
// Synchronous tag FIFO remembering which requester owns each outstanding read.
// Push is ignored when full, pop is ignored when empty; clr_n clears synchronously.
module peridot_qspi_arb_tagfifo
  import peridot_qspi_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] din,
  output logic [TAG_W-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Tag storage; contents are don't-care while the FIFO is empty, so no clear is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/peridot_qspi_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single QSPI PSRAM slave.
// One command is granted at a time (with an idle bubble between grants); read
// owners are queued in a tag FIFO so each readdatavalid beat returns to its issuer.
// Define PERIDOT_QSPI_ARB_RR_EN for round-robin arbitration; otherwise ties are
// resolved by fixed priority chosen with S0_PRIORITY.
module peridot_qspi_arbiter
  import peridot_qspi_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 23,
  parameter int MAX_PENDING = 4,
  parameter int S0_PRIORITY = 1
) (
  input  logic                  csi_clock,
  input  logic                  csi_reset_n,
  input  logic [ADDR_WIDTH-1:0] s0_address,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [31:0]           s0_writedata,
  input  logic [3:0]            s0_byteenable,
  output logic                  s0_waitrequest,
  output logic [31:0]           s0_readdata,
  output logic                  s0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] s1_address,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [31:0]           s1_writedata,
  input  logic [3:0]            s1_byteenable,
  output logic                  s1_waitrequest,
  output logic [31:0]           s1_readdata,
  output logic                  s1_readdatavalid,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [31:0]           m_writedata,
  output logic [3:0]            m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [31:0]           m_readdata,
  input  logic                  m_readdatavalid
);

  arb_state_e       state;
  arb_state_e       state_next;
  logic             s0_req;
  logic             s1_req;
  logic             grant0;
  logic             grant1;
  logic             pick;
  logic             cur_read;
  logic             cur_write;
  logic             accept;
  logic             push;
  logic             fifo_empty;
  logic             fifo_full;
  logic [TAG_W-1:0] head;

  assign s0_req = s0_read | s0_write;
  assign s1_req = s1_read | s1_write;
  assign grant0 = csi_reset_n & (state == ARB_GNT0);
  assign grant1 = csi_reset_n & (state == ARB_GNT1);

`ifdef PERIDOT_QSPI_ARB_RR_EN
  logic rr_ptr;

  // Pointer names the port preferred on the next tie and moves past whoever was just served
  always_ff @(posedge csi_clock) begin
    if (!csi_reset_n) rr_ptr <= 1'b0;
    else if (accept)  rr_ptr <= ~grant1;
  end

  assign pick = (s0_req & s1_req) ? rr_ptr : s1_req;
`else
  assign pick = (s0_req & s1_req) ? (S0_PRIORITY == 0) : s1_req;
`endif

  // Route the granted requester downstream; a full tag FIFO holds back reads but never writes
  always_comb begin
    cur_read       = (grant0 & s0_read)  | (grant1 & s1_read);
    cur_write      = (grant0 & s0_write) | (grant1 & s1_write);
    m_read         = cur_read & ~fifo_full;
    m_write        = cur_write;
    accept         = (m_read | m_write) & ~m_waitrequest;
    m_address      = grant1 ? s1_address    : s0_address;
    m_writedata    = grant1 ? s1_writedata  : s0_writedata;
    m_byteenable   = grant1 ? s1_byteenable : s0_byteenable;
    s0_waitrequest = ~(grant0 & accept);
    s1_waitrequest = ~(grant1 & accept);
  end

  // Grant is held until the command is accepted or the requester withdraws it
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (s0_req | s1_req)   state_next = grant_state(pick);
      ARB_GNT0: if (accept | ~s0_req)  state_next = ARB_IDLE;
      ARB_GNT1: if (accept | ~s1_req)  state_next = ARB_IDLE;
      default:                         state_next = ARB_IDLE;
    endcase
  end

  // Grant state register
  always_ff @(posedge csi_clock) begin
    if (!csi_reset_n) state <= ARB_IDLE;
    else              state <= state_next;
  end

  assign push = accept & m_read;

  peridot_qspi_arb_tagfifo #(
    .DEPTH (MAX_PENDING)
  ) u_tagfifo (
    .clk   (csi_clock),
    .clr_n (csi_reset_n),
    .push  (push),
    .pop   (m_readdatavalid),
    .din   (grant1),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = csi_reset_n & m_readdatavalid & ~fifo_empty & (head == TAG_W'(0));
  assign s1_readdatavalid = csi_reset_n & m_readdatavalid & ~fifo_empty & (head == TAG_W'(1));

endmodule

// File: tb/tb_peridot_qspi_arbiter.sv
// Self-checking bench for peridot_qspi_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model (per-port op queues, owner queue).
module tb_peridot_qspi_arbiter;

  localparam int AW   = 23;
  localparam int MP   = 4;
  localparam int NOPS = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] s0_address, s1_address, m_address;
  logic          s0_read, s0_write, s1_read, s1_write, m_read, m_write;
  logic [31:0]   s0_writedata, s1_writedata, m_writedata;
  logic [3:0]    s0_byteenable, s1_byteenable, m_byteenable;
  logic          s0_waitrequest, s1_waitrequest, m_waitrequest;
  logic [31:0]   s0_readdata, s1_readdata, m_readdata;
  logic          s0_readdatavalid, s1_readdatavalid, m_readdatavalid;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } op_t;

  op_t cur [2];
  bit  active [2];
  int  owner_q [$];

  always #5 clk = ~clk;

  peridot_qspi_arbiter #(
    .ADDR_WIDTH (AW),
    .MAX_PENDING(MP),
    .S0_PRIORITY(1)
  ) dut (
    .csi_clock        (clk),
    .csi_reset_n      (rst_n),
    .s0_address       (s0_address),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_byteenable    (s0_byteenable),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .s1_address       (s1_address),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_writedata     (s1_writedata),
    .s1_byteenable    (s1_byteenable),
    .s1_waitrequest   (s1_waitrequest),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .m_address        (m_address),
    .m_read           (m_read),
    .m_write          (m_write),
    .m_writedata      (m_writedata),
    .m_byteenable     (m_byteenable),
    .m_waitrequest    (m_waitrequest),
    .m_readdata       (m_readdata),
    .m_readdatavalid  (m_readdatavalid)
  );

  task automatic idle_inputs;
    s0_address = '0; s0_read = 0; s0_write = 0; s0_writedata = '0; s0_byteenable = 4'hF;
    s1_address = '0; s1_read = 0; s1_write = 0; s1_writedata = '0; s1_byteenable = 4'hF;
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    s0_read = 1; s1_write = 1; m_readdatavalid = 1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (m_read !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_read got=%0h exp=0", m_read); end
    vectors++; if (m_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_write got=%0h exp=0", m_write); end
    vectors++; if (s0_waitrequest !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_s0_wait got=%0h exp=1", s0_waitrequest); end
    vectors++; if (s1_waitrequest !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_s1_wait got=%0h exp=1", s1_waitrequest); end
    vectors++; if (s0_readdatavalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s0_rdv got=%0h exp=0", s0_readdatavalid); end
    vectors++; if (s1_readdatavalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_s1_rdv got=%0h exp=0", s1_readdatavalid); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_single_read;
    do_reset();
    s0_address = 23'h000010; s0_read = 1;
    #1;
    vectors++; if (m_read !== 1'b0) begin miscompares++; $display("[TB] FAIL bubble_m_read got=%0h exp=0", m_read); end
    vectors++; if (s0_waitrequest !== 1'b1) begin miscompares++; $display("[TB] FAIL bubble_s0_wait got=%0h exp=1", s0_waitrequest); end
    @(negedge clk); #1;
    vectors++; if (m_read !== 1'b1) begin miscompares++; $display("[TB] FAIL single_m_read got=%0h exp=1", m_read); end
    vectors++; if (m_address !== 23'h000010) begin miscompares++; $display("[TB] FAIL single_addr got=%0h exp=10", m_address); end
    vectors++; if (s0_waitrequest !== 1'b0) begin miscompares++; $display("[TB] FAIL single_s0_wait got=%0h exp=0", s0_waitrequest); end
    @(negedge clk);
    s0_read = 0;
    repeat (4) @(negedge clk);
    m_readdatavalid = 1; m_readdata = 32'hDEADBEEF;
    #1;
    vectors++; if (s0_readdatavalid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_s0_rdv got=%0h exp=1", s0_readdatavalid); end
    vectors++; if (s0_readdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL single_data got=%0h exp=deadbeef", s0_readdata); end
    vectors++; if (s1_readdatavalid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_s1_rdv got=%0h exp=0", s1_readdatavalid); end
    @(negedge clk);
    m_readdatavalid = 0;
    #1;
    vectors++; if (s0_readdatavalid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_rdv_one_clk got=%0h exp=0", s0_readdatavalid); end
    m_readdatavalid = 1;
    #1;
    vectors++; if ({s0_readdatavalid, s1_readdatavalid} !== 2'b00) begin miscompares++; $display("[TB] FAIL stray_beat_empty got=%0b exp=00", {s0_readdatavalid, s1_readdatavalid}); end
    @(negedge clk);
    m_readdatavalid = 0;
  endtask

`ifdef PERIDOT_QSPI_ARB_RR_EN
  task automatic test_contention;
    int rq [$];
    int grants;
    int e;
    int g;
    do_reset();
    grants = 0;
    s0_read = 1; s0_address = 23'h000010;
    s1_read = 1; s1_address = 23'h400010;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      @(negedge clk);
      m_readdatavalid = (rq.size() > 0);
      m_readdata = $urandom;
      #1;
      if (m_readdatavalid) begin
        e = rq.pop_front();
        vectors++; if ({s1_readdatavalid, s0_readdatavalid} !== ((e == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL rr_return_tag got=%0b exp_port=%0d", {s1_readdatavalid, s0_readdatavalid}, e); end
      end
      if (!s0_waitrequest || !s1_waitrequest) begin
        g = s0_waitrequest ? 1 : 0;
        vectors++; if (g != grants % 2) begin miscompares++; $display("[TB] FAIL rr_grant_order got=%0d exp=%0d", g, grants % 2); end
        rq.push_back(grants % 2);
        grants++;
      end
    end
    vectors++; if (grants != 8) begin miscompares++; $display("[TB] FAIL rr_grant_count got=%0d exp=8", grants); end
    s0_read = 0; s1_read = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      m_readdatavalid = (rq.size() > 0);
      #1;
      if (m_readdatavalid) begin
        e = rq.pop_front();
        vectors++; if ({s1_readdatavalid, s0_readdatavalid} !== ((e == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL rr_drain_tag got=%0b exp_port=%0d", {s1_readdatavalid, s0_readdatavalid}, e); end
      end
    end
    m_readdatavalid = 0;
  endtask
`else
  task automatic test_contention;
    int n0;
    int n1;
    bit d0;
    bit d1;
    do_reset();
    n0 = 0; n1 = 0;
    s0_write = 1; s0_address = 23'h000100; s0_writedata = 32'hA000_0000;
    s1_write = 1; s1_address = 23'h400200; s1_writedata = 32'hB000_0000;
    for (int c = 0; c < 60 && n1 < 3; c++) begin
      #1;
      d0 = !s0_waitrequest;
      d1 = !s1_waitrequest;
      if (d0) begin
        vectors++; if (m_writedata !== 32'hA000_0000 + n0) begin miscompares++; $display("[TB] FAIL prio_s0_data got=%0h exp=%0h", m_writedata, 32'hA000_0000 + n0); end
        vectors++; if (n1 != 0) begin miscompares++; $display("[TB] FAIL prio_s0_first got=%0d s1 done exp=0", n1); end
        n0++;
      end
      if (d1) begin
        vectors++; if (m_writedata !== 32'hB000_0000 + n1) begin miscompares++; $display("[TB] FAIL prio_s1_data got=%0h exp=%0h", m_writedata, 32'hB000_0000 + n1); end
        vectors++; if (n0 != 4) begin miscompares++; $display("[TB] FAIL prio_s1_starved got=%0d s0 done exp=4", n0); end
        n1++;
      end
      @(negedge clk);
      if (d0) begin if (n0 < 4) s0_writedata = 32'hA000_0000 + n0; else s0_write = 0; end
      if (d1) begin if (n1 < 3) s1_writedata = 32'hB000_0000 + n1; else s1_write = 0; end
    end
    vectors++; if (n0 != 4 || n1 != 3) begin miscompares++; $display("[TB] FAIL prio_completion got=%0d/%0d exp=4/3", n0, n1); end
    idle_inputs();
  endtask
`endif

  task automatic test_fifo_full;
    int acc;
    do_reset();
    acc = 0;
    s0_read = 1; s0_address = 23'h000020;
    for (int c = 0; c < 30 && acc < 4; c++) begin
      @(negedge clk); #1;
      if (!s0_waitrequest) acc++;
    end
    vectors++; if (acc != 4) begin miscompares++; $display("[TB] FAIL full_accept_count got=%0d exp=4", acc); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      vectors++; if ({m_read, s0_waitrequest} !== 2'b01) begin miscompares++; $display("[TB] FAIL full_gate got=%0b exp=01", {m_read, s0_waitrequest}); end
    end
    @(negedge clk);
    m_readdatavalid = 1; m_readdata = 32'h0000_0011;
    #1;
    vectors++; if ({m_read, s0_waitrequest} !== 2'b01) begin miscompares++; $display("[TB] FAIL full_no_bypass got=%0b exp=01", {m_read, s0_waitrequest}); end
    vectors++; if (s0_readdatavalid !== 1'b1) begin miscompares++; $display("[TB] FAIL full_pop_rdv got=%0h exp=1", s0_readdatavalid); end
    @(negedge clk);
    m_readdatavalid = 0;
    #1;
    vectors++; if ({m_read, s0_waitrequest} !== 2'b10) begin miscompares++; $display("[TB] FAIL full_release got=%0b exp=10", {m_read, s0_waitrequest}); end
    @(negedge clk);
    s0_read = 0;
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1; m_readdata = 32'h5500 + i;
      #1;
      vectors++; if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'h5500 + i) begin miscompares++; $display("[TB] FAIL full_drain got=%0h/%0h exp=1/%0h", s0_readdatavalid, s0_readdata, 32'h5500 + i); end
      @(negedge clk);
    end
    m_readdatavalid = 0;
  endtask

  task automatic test_wait_hold;
    do_reset();
    m_waitrequest = 1;
    s1_write = 1; s1_address = 23'h400ABC; s1_writedata = 32'hCAFEF00D; s1_byteenable = 4'b0110;
    @(negedge clk);
    s0_write = 1; s0_address = 23'h000055; s0_writedata = 32'h12345678; s0_byteenable = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++; if ({m_write, m_address, m_writedata, m_byteenable} !== {1'b1, 23'h400ABC, 32'hCAFEF00D, 4'b0110}) begin miscompares++; $display("[TB] FAIL hold_cmd got=%0b/%0h/%0h/%0h exp=1/400abc/cafef00d/6", m_write, m_address, m_writedata, m_byteenable); end
      vectors++; if ({s0_waitrequest, s1_waitrequest} !== 2'b11) begin miscompares++; $display("[TB] FAIL hold_waits got=%0b exp=11", {s0_waitrequest, s1_waitrequest}); end
      @(negedge clk);
    end
    m_waitrequest = 0;
    #1;
    vectors++; if ({s0_waitrequest, s1_waitrequest} !== 2'b10) begin miscompares++; $display("[TB] FAIL hold_release got=%0b exp=10", {s0_waitrequest, s1_waitrequest}); end
    @(negedge clk);
    s1_write = 0;
    #1;
    vectors++; if (s0_waitrequest !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_bubble got=%0h exp=1", s0_waitrequest); end
    @(negedge clk); #1;
    vectors++; if (s0_waitrequest !== 1'b0 || m_writedata !== 32'h12345678) begin miscompares++; $display("[TB] FAIL hold_s0_next got=%0h/%0h exp=0/12345678", s0_waitrequest, m_writedata); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    s0_read = 1; s0_address = 23'h000040;
    @(negedge clk); #1;
    vectors++; if (s0_waitrequest !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_first_read got=%0h exp=0", s0_waitrequest); end
    @(negedge clk);
    s0_read = 0; s1_read = 1; s1_address = 23'h400040;
    @(negedge clk); #1;
    vectors++; if (s1_waitrequest !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_second_read got=%0h exp=0", s1_waitrequest); end
    @(negedge clk);
    s1_read = 0; s0_read = 1;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk); #1;
    vectors++; if ({m_read, s0_waitrequest, s1_waitrequest} !== 3'b011) begin miscompares++; $display("[TB] FAIL mid_reset_outputs got=%0b exp=011", {m_read, s0_waitrequest, s1_waitrequest}); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    m_readdatavalid = 1; m_readdata = 32'hBAD0BAD0;
    #1;
    vectors++; if ({s0_readdatavalid, s1_readdatavalid} !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_fifo_cleared got=%0b exp=00", {s0_readdatavalid, s1_readdatavalid}); end
    @(negedge clk);
    m_readdatavalid = 0;
  endtask

  task automatic drive_port(input int p);
    if (p == 0) begin
      s0_read = active[0] && !cur[0].wr; s0_write = active[0] && cur[0].wr;
      s0_address = cur[0].addr; s0_writedata = cur[0].data; s0_byteenable = cur[0].be;
    end else begin
      s1_read = active[1] && !cur[1].wr; s1_write = active[1] && cur[1].wr;
      s1_address = cur[1].addr; s1_writedata = cur[1].data; s1_byteenable = cur[1].be;
    end
  endtask

  task automatic test_random;
    bit done [2];
    int idle [2];
    int issued [2];
    int completed [2];
    int o;
    int e;
    bit acc;
    logic own_wait;
    logic oth_wait;
    do_reset();
    owner_q.delete();
    for (int p = 0; p < 2; p++) begin
      done[p] = 0; idle[p] = 0; issued[p] = 0; completed[p] = 0; active[p] = 0;
      cur[p].wr = 0; cur[p].addr = '0; cur[p].data = '0; cur[p].be = 4'hF;
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (done[p]) begin
          active[p] = 0; done[p] = 0; completed[p]++;
          idle[p] = 1 + $urandom_range(0, 2);
        end else if (!active[p]) begin
          if (idle[p] > 0) idle[p]--;
          else if (issued[p] < NOPS) begin
            cur[p].wr = $urandom_range(0, 1) == 1;
            cur[p].addr = AW'($urandom);
            cur[p].addr[AW-1] = (p == 1);
            cur[p].data = $urandom;
            cur[p].be = 4'($urandom);
            active[p] = 1;
            issued[p]++;
          end
        end
        drive_port(p);
      end
      m_waitrequest = ($urandom_range(0, 3) == 0);
      m_readdatavalid = (owner_q.size() > 0) && ($urandom_range(0, 2) != 0);
      m_readdata = $urandom;
      #1;
      if (owner_q.size() == MP) begin
        vectors++; if (m_read !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_full_gate got=%0h exp=0", m_read); end
      end
      if (m_readdatavalid) begin
        e = owner_q.pop_front();
        vectors++; if ({s1_readdatavalid, s0_readdatavalid} !== ((e == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL rand_route got=%0b exp_port=%0d", {s1_readdatavalid, s0_readdatavalid}, e); end
        vectors++; if (((e == 1) ? s1_readdata : s0_readdata) !== m_readdata) begin miscompares++; $display("[TB] FAIL rand_rdata got=%0h exp=%0h", (e == 1) ? s1_readdata : s0_readdata, m_readdata); end
      end else begin
        vectors++; if ({s1_readdatavalid, s0_readdatavalid} !== 2'b00) begin miscompares++; $display("[TB] FAIL rand_idle_rdv got=%0b exp=00", {s1_readdatavalid, s0_readdatavalid}); end
      end
      acc = (m_read === 1'b1 || m_write === 1'b1) && !m_waitrequest;
      if (acc) begin
        o = m_address[AW-1] ? 1 : 0;
        own_wait = o ? s1_waitrequest : s0_waitrequest;
        oth_wait = o ? s0_waitrequest : s1_waitrequest;
        vectors++; if (!active[o] || {m_write, m_read} !== (cur[o].wr ? 2'b10 : 2'b01) || m_address !== cur[o].addr || m_byteenable !== cur[o].be || (cur[o].wr && m_writedata !== cur[o].data)) begin
          miscompares++; $display("[TB] FAIL rand_cmd got=%0b%0b/%0h/%0h/%0h exp_port=%0d wr=%0d addr=%0h data=%0h be=%0h", m_write, m_read, m_address, m_writedata, m_byteenable, o, cur[o].wr, cur[o].addr, cur[o].data, cur[o].be);
        end
        vectors++; if ({own_wait, oth_wait} !== 2'b01) begin miscompares++; $display("[TB] FAIL rand_handshake got=%0b exp=01", {own_wait, oth_wait}); end
        if (active[o]) begin
          done[o] = 1;
          if (!cur[o].wr) owner_q.push_back(o);
        end
      end else begin
        vectors++; if ({s0_waitrequest, s1_waitrequest} !== 2'b11) begin miscompares++; $display("[TB] FAIL rand_spurious_ack got=%0b exp=11", {s0_waitrequest, s1_waitrequest}); end
      end
      if (completed[0] == NOPS && completed[1] == NOPS && owner_q.size() == 0) break;
    end
    vectors++; if (completed[0] != NOPS || completed[1] != NOPS || owner_q.size() != 0) begin
      miscompares++; $display("[TB] FAIL rand_completion got=%0d/%0d pending=%0d exp=%0d/%0d pending=0", completed[0], completed[1], owner_q.size(), NOPS, NOPS);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_fifo_full();
    test_wait_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
